// File: rtl/bcd_alu_seq_if.sv
// Request/response bundle for the sequential BCD ALU.
//   start/num1/num2/op          : request side (driven by the master)
//   busy/isValid/res/neg/
//   overflow/err                : response side (driven by the ALU)
interface bcd_alu_seq_if #(
  parameter int DIGITS = 4
);
  localparam int W = 4 * DIGITS;

  logic         start;
  logic [W-1:0] num1;
  logic [W-1:0] num2;
  logic [1:0]   op;
  logic         busy;
  logic         isValid;
  logic [W-1:0] res;
  logic         neg;
  logic         overflow;
  logic         err;

  modport master (
    output start, num1, num2, op,
    input  busy, isValid, res, neg, overflow, err
  );

  modport slave (
    input  start, num1, num2, op,
    output busy, isValid, res, neg, overflow, err
  );
endinterface

// File: rtl/bcd_alu_seq.sv
// Sequential packed-BCD ALU: add, subtract (sign-magnitude) and multiply
// (shift-and-repeated-add) built around one shared DIGITS-wide BCD adder.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset, aborts any operation
//   bus   : bcd_alu_seq_if.slave (start/num1/num2/op in,
//           busy/isValid/res/neg/overflow/err out)
module bcd_alu_seq #(
  parameter int DIGITS = 4
) (
  input logic          clk,
  input logic          reset,
  bcd_alu_seq_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int KW = $clog2(DIGITS);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ADD, S_SUB, S_NEGATE, S_MSHIFT, S_MADD
  } state_t;

  state_t        r_state, w_next;
  logic [W-1:0]  r_n1, r_n2, r_acc, r_res;
  logic [1:0]    r_op;
  logic [3:0]    r_cnt;
  logic [KW-1:0] r_k;
  logic          r_ovf, r_neg, r_ovf_o, r_err, r_valid;

  logic [W-1:0]  w_a, w_b, w_sum, w_shift;
  logic          w_cin, w_cout, w_bad;
  logic [3:0]    w_digit;
  logic          w_ovf_ms, w_ovf_ma;

  function automatic logic [W-1:0] nines(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'd9 - v[4*i +: 4];
    return r;
  endfunction

  always_comb begin : bad_check
    w_bad = (r_op == 2'b11);
    for (int unsigned i = 0; i < DIGITS; i++)
      if (r_n1[4*i +: 4] > 4'd9 || r_n2[4*i +: 4] > 4'd9) w_bad = 1'b1;
  end

  // Shared ripple BCD adder with per-digit +6 correction.
  always_comb begin : adder
    logic [4:0] s;
    logic       c;
    s     = '0;
    c     = w_cin;
    w_sum = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      s = {1'b0, w_a[4*i +: 4]} + {1'b0, w_b[4*i +: 4]} + {4'b0, c};
      if (s > 5'd9) begin
        s = s + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      w_sum[4*i +: 4] = s[3:0];
    end
    w_cout = c;
  end

  assign w_digit  = r_n2[4*r_k +: 4];
  assign w_shift  = {r_acc[W-5:0], 4'h0};
  assign w_ovf_ms = r_ovf | (r_acc[W-1:W-4] != 4'h0);
  assign w_ovf_ma = r_ovf | w_cout;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_next = S_CHECK;
      S_CHECK: begin
        if (w_bad)              w_next = S_IDLE;
        else if (r_op == 2'b00) w_next = S_ADD;
        else if (r_op == 2'b01) w_next = S_SUB;
        else                    w_next = S_MSHIFT;
      end
      S_ADD:    w_next = S_IDLE;
      S_SUB:    w_next = w_cout ? S_IDLE : S_NEGATE;
      S_NEGATE: w_next = S_IDLE;
      S_MSHIFT: begin
        if (w_digit != 4'd0)   w_next = S_MADD;
        else if (r_k == '0)    w_next = S_IDLE;
      end
      S_MADD: begin
        if (r_cnt == 4'd1) w_next = (r_k == '0) ? S_IDLE : S_MSHIFT;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Output / adder-operand logic
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_cin = 1'b0;
    case (r_state)
      S_ADD:    begin w_a = r_n1;         w_b = r_n2;        end
      S_SUB:    begin w_a = r_n1;         w_b = nines(r_n2); w_cin = 1'b1; end
      S_NEGATE: begin w_a = nines(r_acc);                    w_cin = 1'b1; end
      S_MADD:   begin w_a = r_acc;        w_b = r_n1;        end
      default:  ;
    endcase
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.isValid  = r_valid;
  assign bus.res      = r_res;
  assign bus.neg      = r_neg;
  assign bus.overflow = r_ovf_o;
  assign bus.err      = r_err;

  // Datapath: visible outputs only change on a result edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_n1 <= '0; r_n2 <= '0; r_op <= '0; r_acc <= '0;
      r_cnt <= '0; r_k <= '0; r_ovf <= 1'b0;
      r_res <= '0; r_neg <= 1'b0; r_ovf_o <= 1'b0; r_err <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_n1 <= bus.num1; r_n2 <= bus.num2; r_op <= bus.op;
        end
        S_CHECK: begin
          r_acc <= '0;
          r_ovf <= 1'b0;
          r_k   <= KW'(DIGITS - 1);
          if (w_bad) begin
            r_res <= '0; r_neg <= 1'b0; r_ovf_o <= 1'b0; r_err <= 1'b1;
            r_valid <= 1'b1;
          end
        end
        S_ADD: begin
          r_res <= w_sum; r_neg <= 1'b0; r_ovf_o <= w_cout; r_err <= 1'b0;
          r_valid <= 1'b1;
        end
        S_SUB: begin
          r_acc <= w_sum;
          if (w_cout) begin
            r_res <= w_sum; r_neg <= 1'b0; r_ovf_o <= 1'b0; r_err <= 1'b0;
            r_valid <= 1'b1;
          end
        end
        S_NEGATE: begin
          r_res <= w_sum; r_neg <= 1'b1; r_ovf_o <= 1'b0; r_err <= 1'b0;
          r_valid <= 1'b1;
        end
        S_MSHIFT: begin
          r_acc <= w_shift;
          r_ovf <= w_ovf_ms;
          r_cnt <= w_digit;
          if (w_digit == 4'd0) begin
            if (r_k == '0) begin
              // Zero LSD: the shifted accumulator is the final product.
              r_res <= w_shift; r_neg <= 1'b0; r_ovf_o <= w_ovf_ms; r_err <= 1'b0;
              r_valid <= 1'b1;
            end else begin
              r_k <= r_k - 1'b1;
            end
          end
        end
        S_MADD: begin
          r_acc <= w_sum;
          r_ovf <= w_ovf_ma;
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            if (r_k == '0) begin
              r_res <= w_sum; r_neg <= 1'b0; r_ovf_o <= w_ovf_ma; r_err <= 1'b0;
              r_valid <= 1'b1;
            end else begin
              r_k <= r_k - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_alu_seq.sv
// Scoreboard bench for bcd_alu_seq (DIGITS=4): directed vectors push
// expected responses, a monitor pops and compares on every isValid.
module tb_bcd_alu_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic        neg, ovf, err;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t q[$];

  bcd_alu_seq_if #(.DIGITS(4)) bus ();

  bcd_alu_seq #(.DIGITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.isValid === 1'b1) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_isValid at cycle %0d: got isValid=1, expected none", cyc);
        end else begin
          e = q.pop_front();
          chk({e.name, ".res"},      32'(bus.res),      32'(e.res));
          chk({e.name, ".neg"},      32'(bus.neg),      32'(e.neg));
          chk({e.name, ".overflow"}, 32'(bus.overflow), 32'(e.ovf));
          chk({e.name, ".err"},      32'(bus.err),      32'(e.err));
          chk({e.name, ".latency"},  32'(cyc - e.acc_cyc), 32'(e.lat));
          chk({e.name, ".busy_at_result"}, 32'(bus.busy), 32'd0);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_op(string nm, logic [15:0] a, logic [15:0] b, logic [1:0] o,
                       logic [15:0] er, logic en, logic eo, logic ee, int lat);
    exp_t e;
    wait_idle();
    @(negedge clk);
    bus.start = 1'b1; bus.num1 = a; bus.num2 = b; bus.op = o;
    @(posedge clk);
    #1;
    e.name = nm; e.res = er; e.neg = en; e.ovf = eo; e.err = ee;
    e.lat = lat; e.acc_cyc = cyc;
    q.push_back(e);
    chk({nm, ".busy_after_accept"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    // Scramble inputs: they must be ignored after the accept edge.
    bus.start = 1'b0; bus.num1 = 16'h9999; bus.num2 = 16'h8888; bus.op = 2'b00;
  endtask

  task automatic chk_cleared(string nm);
    chk({nm, ".busy"},     32'(bus.busy),     32'd0);
    chk({nm, ".isValid"},  32'(bus.isValid),  32'd0);
    chk({nm, ".res"},      32'(bus.res),      32'd0);
    chk({nm, ".neg"},      32'(bus.neg),      32'd0);
    chk({nm, ".overflow"}, 32'(bus.overflow), 32'd0);
    chk({nm, ".err"},      32'(bus.err),      32'd0);
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.num1 = '0; bus.num2 = '0; bus.op = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_cleared("reset_state");
    @(negedge clk);
    reset = 1'b0;

    do_op("add_1234_5678", 16'h1234, 16'h5678, 2'b00, 16'h6912, 1'b0, 1'b0, 1'b0, 2);
    do_op("add_9999_0001", 16'h9999, 16'h0001, 2'b00, 16'h0000, 1'b0, 1'b1, 1'b0, 2);
    do_op("sub_0100_0250", 16'h0100, 16'h0250, 2'b01, 16'h0150, 1'b1, 1'b0, 1'b0, 3);
    do_op("sub_0500_0500", 16'h0500, 16'h0500, 2'b01, 16'h0000, 1'b0, 1'b0, 1'b0, 2);
    do_op("sub_0750_0250", 16'h0750, 16'h0250, 2'b01, 16'h0500, 1'b0, 1'b0, 1'b0, 2);
    do_op("err_digit",     16'h12A4, 16'h0001, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b1, 1);
    do_op("err_op11",      16'h1111, 16'h2222, 2'b11, 16'h0000, 1'b0, 1'b0, 1'b1, 1);
    do_op("mul_0123_0045", 16'h0123, 16'h0045, 2'b10, 16'h5535, 1'b0, 1'b0, 1'b0, 14);

    // start pulsed while busy must be ignored (no extra isValid).
    @(negedge clk);
    bus.start = 1'b1; bus.num1 = 16'h0001; bus.num2 = 16'h0001; bus.op = 2'b00;
    @(negedge clk);
    bus.start = 1'b0;

    do_op("mul_5000_0003", 16'h5000, 16'h0003, 2'b10, 16'h5000, 1'b0, 1'b1, 1'b0, 8);

    // Abort a long multiply with reset.
    wait_idle();
    @(negedge clk);
    bus.start = 1'b1; bus.num1 = 16'h0999; bus.num2 = 16'h0999; bus.op = 2'b10;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_cleared("reset_abort");
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);

    do_op("add_0001_0002", 16'h0001, 16'h0002, 2'b00, 16'h0003, 1'b0, 1'b0, 1'b0, 2);

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
